// File: rtl/frac_uint_multiplier.sv
// frac_uint_multiplier: bit-serial signed-fraction x unsigned-integer multiplier, one partial product per CE cycle.
//
// Ports:
//   i_clk          system clock
//   i_reset        synchronous active-high reset (priority over i_ce)
//   i_ce           clock enable; when low all state, including outputs, holds
//   i_in_valid     operands present this cycle
//   i_frac_in      signed Q0.(FRAC_BITS-1) fraction
//   i_b_in         unsigned integer operand
//   o_in_ready     block idle; operands accepted on i_in_valid & o_in_ready & i_ce
//   o_result_ready one-CE-cycle pulse marking a new o_mul_result
//   o_mul_result   signed result (i_frac_in * i_b_in) >>> (FRAC_BITS-1), held until the next result
//
// Build option: define THEREMIN_MUL_ROUND_EN to round half up instead of flooring.
module frac_uint_multiplier #(
    parameter int OPERAND_BITS = 30,
    parameter int FRAC_BITS    = 25
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_ce,
    input  logic                         i_in_valid,
    input  logic [FRAC_BITS-1:0]         i_frac_in,
    input  logic [OPERAND_BITS-1:0]      i_b_in,
    output logic                         o_in_ready,
    output logic                         o_result_ready,
    output logic signed [OPERAND_BITS:0] o_mul_result
);
    // F+O bits hold the exact product; the accumulator only ever needs one bit less
    // before the final step, since at most FRAC_BITS-1 fraction bits have been folded in.
    localparam int AW = FRAC_BITS + OPERAND_BITS;
    localparam int CW = $clog2(FRAC_BITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(FRAC_BITS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      r_state;
    logic [FRAC_BITS-1:0]        r_frac;
    logic [OPERAND_BITS-1:0]     r_b;
    logic [AW-2:0]               r_acc;
    logic [CW-1:0]               r_cnt;
    logic                        r_result_ready;
    logic signed [OPERAND_BITS:0] r_mul_result;

    logic [AW-1:0]               w_b_ext;
    logic [AW-1:0]               w_addend;
    logic [AW-1:0]               w_acc_next;
    logic [OPERAND_BITS:0]       w_result;

    // MSB-first Horner evaluation: the sign bit, processed first, carries weight -1.
    assign w_b_ext    = {{FRAC_BITS{1'b0}}, r_b};
    assign w_addend   = !r_frac[r_cnt] ? '0 : (r_cnt == CNT_MAX ? -w_b_ext : w_b_ext);
    assign w_acc_next = {r_acc, 1'b0} + w_addend;

`ifdef THEREMIN_MUL_ROUND_EN
    // Adding half an LSB before flooring equals adding the first discarded bit after flooring.
    assign w_result = w_acc_next[AW-1 -: OPERAND_BITS+1] + (OPERAND_BITS+1)'(w_acc_next[FRAC_BITS-2]);
`else
    assign w_result = w_acc_next[AW-1 -: OPERAND_BITS+1];
`endif

    assign o_in_ready     = (r_state == IDLE);
    assign o_result_ready = r_result_ready;
    assign o_mul_result   = r_mul_result;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= IDLE;
            r_frac         <= '0;
            r_b            <= '0;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_result_ready <= 1'b0;
            r_mul_result   <= '0;
        end else if (i_ce) begin
            r_result_ready <= 1'b0;
            if (r_state == IDLE) begin
                if (i_in_valid) begin
                    r_frac  <= i_frac_in;
                    r_b     <= i_b_in;
                    r_acc   <= '0;
                    r_cnt   <= CNT_MAX;
                    r_state <= RUN;
                end
            end else begin
                r_acc <= w_acc_next[AW-2:0];
                r_cnt <= r_cnt - CW'(1);
                if (r_cnt == '0) begin
                    r_mul_result   <= w_result;
                    r_result_ready <= 1'b1;
                    r_state        <= IDLE;
                end
            end
        end
    end
endmodule
